// File: rtl/fgen_trig_seq_pkg.sv
// Shared definitions for the trigger sequencer: local register offsets,
// ctrl bit positions, bus widths, FSM state encoding and the address
// decode helper.
package fgen_trig_seq_pkg;

    localparam int LB_AW = 16;
    localparam int LB_DW = 32;

    localparam logic [3:0] OFS_CTRL    = 4'd0;
    localparam logic [3:0] OFS_PERIOD  = 4'd1;
    localparam logic [3:0] OFS_DELAY   = 4'd2;
    localparam logic [3:0] OFS_HOLDOFF = 4'd3;
    localparam logic [3:0] OFS_BURST   = 4'd4;
    localparam logic [3:0] OFS_STRIKE  = 4'd5;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_SRC = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_FIRE,
        ST_HOLDOFF
    } seq_state_t;

    // The local block occupies 16 addresses starting at 16*blk.
    function automatic logic is_local(input logic [LB_AW-1:0] addr, input logic [LB_AW-5:0] blk);
        return addr[LB_AW-1:4] == blk;
    endfunction

endpackage

// File: rtl/fgen_trig_seq_if.sv
// Local register write bus (data/write/addr).
//   master : drives data, write, addr
//   slave  : receives data, write, addr
interface fgen_trig_seq_if;
    import fgen_trig_seq_pkg::*;

    logic [LB_DW-1:0] data;
    logic             write;
    logic [LB_AW-1:0] addr;

    modport master (output data, write, addr);
    modport slave  (input  data, write, addr);

endinterface

// File: rtl/fgen_trig_seq_load_downcount.sv
// Loadable down-counter with zero flag; stops at zero unless reloaded.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force count to zero (priority over load)
//   load      : load load_val
//   dec       : decrement when non-zero
//   zero      : count == 0
module fgen_trig_seq_load_downcount #(
    parameter int cw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          dec,
    input  logic [cw-1:0] load_val,
    output logic          zero
);

    logic [cw-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - cw'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fgen_trig_seq.sv
// Trigger sequencer ahead of the function generator. Picks a trigger
// source (period timer, external edge, software strike), applies delay,
// holdoff and burst counting, and emits a single-cycle trig. Sits in the
// local write bus: writes to its own 16-address block are consumed, all
// others pass through with one cycle of latency.
//   clk, rst  : clock, synchronous active-high reset
//   lb        : controlling write bus (slave)
//   lbo       : controlled write bus, registered (master)
//   ext_trig  : external event, rising edge counts
//   trig      : one-cycle trigger
//   busy      : state other than IDLE
//   missed    : saturating count of events dropped in DELAY/FIRE/HOLDOFF
//
// state    | meaning
// IDLE     | disabled, waiting for an enable write
// ARMED    | waiting for an event
// DELAY    | counting the programmed delay before firing
// FIRE     | trig asserted for this single cycle
// HOLDOFF  | ignoring events for the programmed holdoff
module fgen_trig_seq
    import fgen_trig_seq_pkg::*;
#(
    parameter logic [11:0] addr_hi = 12'd1,
    parameter int          cw      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    fgen_trig_seq_if.slave        lb,
    fgen_trig_seq_if.master       lbo,
    input  logic                  ext_trig,
    output logic                  trig,
    output logic                  busy,
    output logic [15:0]           missed
);

    logic          ctrl_en, ctrl_src, ext_d, burst_inf;
    logic [cw-1:0] period, delay_v, holdoff, burst, remaining;
    seq_state_t    state;

    logic       wr_local, wr_ctrl, wr_period, wr_delay, wr_holdoff, wr_burst, wr_strike;
    logic       abort, tick, evt, last_shot, drop_win;
    logic       tmr_zero, dly_zero, hld_zero;
    logic [3:0] ofs;

    assign wr_local   = lb.write && is_local(lb.addr, addr_hi);
    assign ofs        = lb.addr[3:0];
    assign wr_ctrl    = wr_local && (ofs == OFS_CTRL);
    assign wr_period  = wr_local && (ofs == OFS_PERIOD);
    assign wr_delay   = wr_local && (ofs == OFS_DELAY);
    assign wr_holdoff = wr_local && (ofs == OFS_HOLDOFF);
    assign wr_burst   = wr_local && (ofs == OFS_BURST);
    assign wr_strike  = wr_local && (ofs == OFS_STRIKE);

    // Disabling wins over everything else in the same cycle.
    assign abort = wr_ctrl && !lb.data[CTRL_EN];

    assign tick      = ctrl_en && (period != '0) && tmr_zero;
    assign evt       = (!ctrl_src && tick) || (ctrl_src && ext_trig && !ext_d) || wr_strike;
    assign last_shot = !burst_inf && (remaining == cw'(1));
    assign drop_win  = (state == ST_DELAY) || (state == ST_FIRE) || (state == ST_HOLDOFF);

    fgen_trig_seq_load_downcount #(.cw(cw)) u_timer (
        .clk(clk), .rst(rst), .clr(!ctrl_en || abort),
        .load(tick), .dec(ctrl_en && (period != '0)),
        .load_val(period - cw'(1)), .zero(tmr_zero)
    );

    fgen_trig_seq_load_downcount #(.cw(cw)) u_delay (
        .clk(clk), .rst(rst), .clr(!ctrl_en || abort),
        .load((state == ST_ARMED) && evt && (delay_v != '0)), .dec(state == ST_DELAY),
        .load_val(delay_v - cw'(1)), .zero(dly_zero)
    );

    fgen_trig_seq_load_downcount #(.cw(cw)) u_holdoff (
        .clk(clk), .rst(rst), .clr(!ctrl_en || abort),
        .load((state == ST_FIRE) && !last_shot && (holdoff != '0)), .dec(state == ST_HOLDOFF),
        .load_val(holdoff - cw'(1)), .zero(hld_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lbo.data  <= '0;
            lbo.addr  <= '0;
            lbo.write <= 1'b0;
            ext_d     <= 1'b0;
            ctrl_src  <= 1'b0;
            period    <= '0;
            delay_v   <= '0;
            holdoff   <= '0;
            burst     <= '0;
            missed    <= '0;
        end else begin
            lbo.data  <= lb.data;
            lbo.addr  <= lb.addr;
            lbo.write <= lb.write && !wr_local;
            ext_d     <= ext_trig;
            if (wr_ctrl)    ctrl_src <= lb.data[CTRL_SRC];
            if (wr_period)  period   <= lb.data[cw-1:0];
            if (wr_delay)   delay_v  <= lb.data[cw-1:0];
            if (wr_holdoff) holdoff  <= lb.data[cw-1:0];
            if (wr_burst)   burst    <= lb.data[cw-1:0];
            if (evt && drop_win && (missed != 16'hffff)) missed <= missed + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            trig      <= 1'b0;
            busy      <= 1'b0;
            ctrl_en   <= 1'b0;
            remaining <= '0;
            burst_inf <= 1'b0;
        end else begin
            trig <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                ctrl_en <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: if (wr_ctrl && lb.data[CTRL_EN]) begin
                        state     <= ST_ARMED;
                        busy      <= 1'b1;
                        ctrl_en   <= 1'b1;
                        remaining <= burst;
                        burst_inf <= (burst == '0);
                    end
                    ST_ARMED: if (evt) begin
                        if (delay_v == '0) begin
                            state <= ST_FIRE;
                            trig  <= 1'b1;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end
                    ST_DELAY: if (dly_zero) begin
                        state <= ST_FIRE;
                        trig  <= 1'b1;
                    end
                    ST_FIRE: if (last_shot) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        ctrl_en <= 1'b0;
                    end else begin
                        if (!burst_inf) remaining <= remaining - cw'(1);
                        state <= (holdoff != '0) ? ST_HOLDOFF : ST_ARMED;
                    end
                    ST_HOLDOFF: if (hld_zero) state <= ST_ARMED;
                    default: begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        ctrl_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fgen_trig_seq.sv
module tb_fgen_trig_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_trig = 1'b0;
    logic        trig, busy;
    logic [15:0] missed;

    fgen_trig_seq_if lb_bus ();
    fgen_trig_seq_if lbo_bus ();

    fgen_trig_seq #(.addr_hi(12'd1), .cw(32)) dut (
        .clk(clk), .rst(rst), .lb(lb_bus), .lbo(lbo_bus),
        .ext_trig(ext_trig), .trig(trig), .busy(busy), .missed(missed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit ext_arr [256];
    bit strk_arr [256];
    int exp_q [$];
    int obs_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        lb_bus.write = 1'b1;
        lb_bus.addr  = a;
        lb_bus.data  = d;
        @(posedge clk); #1;
        lb_bus.write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lb_bus.write = 1'b0;
        ext_trig = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 256; i++) begin
            ext_arr[i]  = 1'b0;
            strk_arr[i] = 1'b0;
        end
    endtask

    task automatic gen_random(input int n);
        bit lvl;
        lvl = 1'b0;
        clear_stim();
        for (int c = 1; c < n - 1; c++) begin
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            ext_arr[c] = lvl;
            if ($urandom_range(0, 24) == 0) strk_arr[c] = 1'b1;
        end
    endtask

    // Event-list model: an event is taken when the sequencer is ready again,
    // firing D+1 cycles later; anything arriving before re-arm is missed.
    task automatic model(input bit src, input int p, input int d, input int h, input int b,
                         input int n, input int abort_at, output int m, output bit bz);
        int  ready, fired, t_last, t;
        bit  done, ev;
        ready = 1; fired = 0; t_last = 0; done = 1'b0; m = 0;
        exp_q.delete();
        for (int c = 1; c < n; c++) begin
            if (abort_at >= 0 && c > abort_at) break;
            ev = (!src && p > 0 && ((c - 1) % p) == 0) ||
                 (src && ext_arr[c] && !ext_arr[c-1]) ||
                 (strk_arr[c] && c != abort_at);
            if (!ev) continue;
            if (done && c > t_last) continue;
            if (!done && c >= ready) begin
                t = c + d + 1;
                if (t <= n && (abort_at < 0 || t <= abort_at)) exp_q.push_back(t);
                fired++;
                if (b != 0 && fired == b) begin
                    done = 1'b1;
                    t_last = t;
                end else begin
                    ready = t + h + 1;
                end
            end else begin
                m++;
            end
        end
        if (abort_at >= 0) bz = 1'b0;
        else if (done)     bz = (t_last >= n);
        else               bz = 1'b1;
    endtask

    task automatic run_scn(input string tag, input bit src, input int p, input int d,
                           input int h, input int b, input int n, input int abort_at,
                           input int base_missed);
        int em;
        bit eb;
        bus_write(16'h0011, p);
        bus_write(16'h0012, d);
        bus_write(16'h0013, h);
        bus_write(16'h0014, b);
        obs_q.delete();
        for (int k = 0; k < n; k++) begin
            lb_bus.write = 1'b0;
            if (k == 0) begin
                lb_bus.write = 1'b1; lb_bus.addr = 16'h0010; lb_bus.data = {30'd0, src, 1'b1};
            end else if (k == abort_at) begin
                lb_bus.write = 1'b1; lb_bus.addr = 16'h0010; lb_bus.data = {30'd0, src, 1'b0};
            end else if (strk_arr[k]) begin
                lb_bus.write = 1'b1; lb_bus.addr = 16'h0015; lb_bus.data = $urandom;
            end
            ext_trig = ext_arr[k];
            @(posedge clk); #1;
            if (trig) obs_q.push_back(k + 1);
        end
        lb_bus.write = 1'b0;
        ext_trig = 1'b0;
        model(src, p, d, h, b, n, abort_at, em, eb);
        chk({tag, " trig_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s trig_cycle[%0d]", tag, i), obs_q[i], exp_q[i]);
        chk({tag, " missed"}, {16'd0, missed}, base_missed + em);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
    endtask

    initial begin
        int n, ab;
        lb_bus.write = 1'b0;
        lb_bus.addr  = '0;
        lb_bus.data  = '0;
        clear_stim();
        do_reset();
        chk("rst trig", {31'd0, trig}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst missed", {16'd0, missed}, 0);
        chk("rst lbo_write", {31'd0, lbo_bus.write}, 0);
        chk("rst lbo_addr", {16'd0, lbo_bus.addr}, 0);
        chk("rst lbo_data", lbo_bus.data, 0);

        // pass-through and local consumption
        bus_write(16'h0042, 32'hdeadbeef);
        chk("pass lbo_write", {31'd0, lbo_bus.write}, 1);
        chk("pass lbo_addr", {16'd0, lbo_bus.addr}, 32'h0042);
        chk("pass lbo_data", lbo_bus.data, 32'hdeadbeef);
        bus_write(16'h0011, 32'h0000_0005);
        chk("local lbo_write", {31'd0, lbo_bus.write}, 0);
        chk("local lbo_addr", {16'd0, lbo_bus.addr}, 32'h0011);
        bus_write(16'h0100, 32'h1234_5678);
        chk("pass2 lbo_write", {31'd0, lbo_bus.write}, 1);
        @(posedge clk); #1;
        chk("idle lbo_write", {31'd0, lbo_bus.write}, 0);

        do_reset(); clear_stim();
        run_scn("periodic", 1'b0, 10, 0, 0, 0, 60, -1, 0);

        do_reset(); clear_stim();
        ext_arr[5] = 1'b1; ext_arr[15] = 1'b1;
        run_scn("dly_hold", 1'b1, 0, 3, 20, 0, 40, -1, 0);

        do_reset(); clear_stim();
        run_scn("burst1", 1'b0, 8, 0, 0, 3, 40, -1, 0);
        run_scn("burst2", 1'b0, 8, 0, 0, 3, 40, -1, 0);

        do_reset(); clear_stim();
        ext_arr[5] = 1'b1; strk_arr[5] = 1'b1;
        run_scn("coinc", 1'b1, 0, 0, 0, 0, 12, -1, 0);

        do_reset(); clear_stim();
        ext_arr[3] = 1'b1;
        run_scn("abort", 1'b1, 0, 5, 0, 0, 15, 6, 0);

        do_reset(); clear_stim();
        ext_arr[2] = 1'b1; ext_arr[10] = 1'b1;
        run_scn("rsthold", 1'b1, 0, 0, 30, 0, 20, -1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rsthold trig", {31'd0, trig}, 0);
        chk("rsthold busy", {31'd0, busy}, 0);
        chk("rsthold missed", {16'd0, missed}, 0);
        chk("rsthold lbo_write", {31'd0, lbo_bus.write}, 0);
        rst = 1'b0;

        for (int s = 0; s < 12; s++) begin
            do_reset();
            n = 150;
            gen_random(n);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, n - 2)) : -1;
            run_scn($sformatf("rand%0d", s), 1'(($urandom_range(0, 1))),
                    int'($urandom_range(1, 12)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 4)), n, ab, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
